// File: rtl/cpu_sequencer_fsm.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM for the CPU core.
// Optional memory-wait timeout with sticky bus_error is enabled by defining MEM_TIMEOUT_EN.
module cpu_sequencer_fsm #(
  parameter logic [5:0]  OP_RTYPE       = 6'b000000,
  parameter logic [5:0]  OP_ADDI        = 6'b001000,
  parameter logic [5:0]  OP_LW          = 6'b100011,
  parameter logic [5:0]  OP_SW          = 6'b101011,
  parameter logic [5:0]  OP_BEQ         = 6'b000100,
  parameter logic [5:0]  OP_J           = 6'b000010,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic [5:0]  op,
  input  logic        alu_zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        is_branch,
  output logic        add_imm,
  output logic        load_word,
  output logic        store_word,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        pc_en,
  output logic        pc_sel_target,
  output logic        illegal_op,
  output logic        bus_error,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  opq_q, opq_d;
  logic [31:0] count_q, count_d;
  logic        retire;

  logic op_legal;
  logic c_rtype, c_addi, c_lw, c_sw, c_beq, c_j;
  logic in_instr;

  assign op_legal = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
                    (op == OP_SW)    || (op == OP_BEQ)  || (op == OP_J);

  assign c_rtype = (opq_q == OP_RTYPE);
  assign c_addi  = (opq_q == OP_ADDI);
  assign c_lw    = (opq_q == OP_LW);
  assign c_sw    = (opq_q == OP_SW);
  assign c_beq   = (opq_q == OP_BEQ);
  assign c_j     = (opq_q == OP_J);

  assign in_instr = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              berr_q, berr_d;
  logic              waiting;
  logic              timeout;

  assign waiting = ((state_q == S_FETCH) && !imem_ready) ||
                   ((state_q == S_MEM)   && !dmem_ready);
  // Trips on the TIMEOUT_CYCLES-th consecutive ready=0 cycle; req drops the cycle after.
  assign timeout = waiting && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    berr_d = berr_q | timeout;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      berr_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      berr_q <= berr_d;
    end
  end

  assign bus_error = berr_q;
`else
  logic timeout;
  assign timeout   = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opq_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      opq_q   <= opq_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opq_d   = opq_q;
    unique case (state_q)
      S_IDLE: begin
        if (!halt) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready)   state_d = S_DECODE;
        else if (timeout) state_d = S_IDLE;
      end
      S_DECODE: begin
        opq_d   = op;
        state_d = op_legal ? S_EXEC : S_IDLE;
      end
      S_EXEC: begin
        if (c_rtype || c_addi)  state_d = S_WB;
        else if (c_lw || c_sw)  state_d = S_MEM;
        else                    state_d = S_IDLE;
      end
      S_MEM: begin
        if (dmem_ready)   state_d = c_lw ? S_WB : S_IDLE;
        else if (timeout) state_d = S_IDLE;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    alu_src_imm   = 1'b0;
    reg_we        = 1'b0;
    pc_en         = 1'b0;
    pc_sel_target = 1'b0;
    illegal_op    = 1'b0;
    retire        = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      S_DECODE: begin
        illegal_op = !op_legal;
        pc_en      = !op_legal;
      end
      S_EXEC: begin
        alu_src_imm = c_addi || c_lw || c_sw;
        if (c_beq || c_j) begin
          pc_en         = 1'b1;
          pc_sel_target = c_j || alu_zero;
          retire        = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = c_sw;
        if (c_sw && dmem_ready) begin
          pc_en  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  assign count_d = count_q + {31'd0, retire};

  assign is_branch   = in_instr && (c_beq || c_j);
  assign add_imm     = in_instr && c_addi;
  assign load_word   = in_instr && c_lw;
  assign store_word  = in_instr && c_sw;
  assign instr_count = count_q;

endmodule

// File: doc/cpu_sequencer_fsm.md
Name: cpu_sequencer_fsm

Overview:
- Multi-cycle control FSM for the CPU core.
- Sequences instruction fetch, decode, execute, data-memory access and register writeback around the existing instruction decoder and ALU.
- Generates the decoder class strobes (is_branch, add_imm, load_word, store_word) and the datapath enables.
- Handshakes with instruction and data memory via req/ready.

Parameters:
- OP_RTYPE, 6'b000000, R-type ALU op
- OP_ADDI, 6'b001000, add immediate
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_J, 6'b000010, jump
- TIMEOUT_CYCLES, 255, memory wait limit (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  hold core in IDLE, sampled in IDLE only
- op  in  6  opcode from decoder, instruction[31:26]
- alu_zero  in  1  ALU zero flag, valid in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_load  out  1  latch instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- is_branch  out  1  decoder strobe: branch/jump class
- add_imm  out  1  decoder strobe: ADDI class
- load_word  out  1  decoder strobe: LW class
- store_word  out  1  decoder strobe: SW class
- alu_src_imm  out  1  ALU operand B = sign-extended immediate
- reg_we  out  1  register file write enable
- pc_en  out  1  PC update
- pc_sel_target  out  1  PC takes branch/jump target (else PC+4)
- illegal_op  out  1  one-cycle pulse on unknown opcode
- bus_error  out  1  sticky memory timeout flag
- instr_count  out  32  retired instruction counter

Behaviour:
- Reset (async, rst_n=0): state=IDLE, latched opcode=0, instr_count=0, bus_error=0, every output 0.
- Latched opcode opq captured from op on the DECODE cycle. Class strobes are decoded from opq, asserted from EXEC until the instruction retires, 0 otherwise.
- IDLE: halt=1 -> stay; else -> FETCH.
- FETCH: imem_req=1 held until imem_ready=1; that cycle ir_load=1 -> DECODE.
- DECODE: capture opq. Unknown op: illegal_op=1, pc_en=1 (PC+4), no retire count -> IDLE.
- EXEC:
  - RTYPE/ADDI -> WB.
  - LW/SW -> MEM.
  - BEQ: pc_en=1; pc_sel_target=alu_zero -> IDLE (retire).
  - J: pc_en=1, pc_sel_target=1 -> IDLE (retire).
  - alu_src_imm=1 for ADDI/LW/SW.
- MEM: dmem_req=1; dmem_we=1 for SW. Held until dmem_ready=1.
  - LW -> WB.
  - SW: pc_en=1 on the ready cycle -> IDLE (retire).
- WB: reg_we=1, pc_en=1 for one cycle -> IDLE (retire).
- Retire: instr_count+1 on the retiring cycle, wraps 0xFFFFFFFF -> 0.
- Zero-wait latency from IDLE, in cycles incl. IDLE: BEQ/J 4, RTYPE/ADDI 5, SW 5, LW 6. Each ready-wait cycle adds 1.
- req stays asserted while ready=0; req is never withdrawn before ready. ready while req=0 is ignored.
- halt asserted mid-instruction: no effect until the next IDLE.
- Reset mid-operation: immediate return to IDLE. Pending memory requests are dropped; memories treat req falling as abort.
- Strobes are mutually exclusive; at most one of is_branch/add_imm/load_word/store_word is high.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 8-bit+ wait counter counts cycles in FETCH or MEM with ready=0.
  - When the counter reaches TIMEOUT_CYCLES: drop req, set bus_error=1 (sticky until reset), go to IDLE. No retire, no pc_en.
  - Counter clears on every state entry.
- MEM_TIMEOUT_EN undefined: waits are unbounded; bus_error is tied 0 and no counter logic exists.

Test Plan:
- Reset, then RTYPE with imem_ready/dmem_ready always 1 -> states IDLE,FETCH,DECODE,EXEC,WB; reg_we=1 at cycle 5 for exactly one cycle; instr_count=1.
- LW with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, load_word=1, reg_we pulse after ready; total 9 cycles.
- BEQ with alu_zero=1, then BEQ with alu_zero=0 -> pc_sel_target 1 then 0, each with a single pc_en pulse; reg_we never high; instr_count=2.
- SW with dmem_ready=1 -> dmem_we=1, store_word=1, alu_src_imm=1; no reg_we; retire in MEM cycle.
- op=6'b111111 -> illegal_op one-cycle pulse, pc_en=1, instr_count unchanged. Also: halt=1 in IDLE -> no imem_req for 10 cycles.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_ready=0 -> bus_error=1 after 4 wait cycles, imem_req drops, state IDLE. Also: rst_n low mid-MEM -> all outputs 0 asynchronously.
